// File: rtl/nibble_parity_pkg.sv
// Shared types and helpers for the nibble parity checker.
package nibble_parity_pkg;

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_CHECK  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  // Odd parity of a nibble {a,b,c,d}: a^b^c^d.
  function automatic logic nib_parity(input logic [3:0] nib);
    return ^nib;
  endfunction

endpackage

// File: rtl/nibble_parity.sv
// Combinational 4-input odd-parity stage.
module nibble_parity
  import nibble_parity_pkg::*;
(
  input  logic [3:0] nib,
  output logic       par
);

  assign par = nib_parity(nib);

endmodule

// File: rtl/nibble_parity_checker.sv
// Frame checker: FRAME_LEN data nibbles plus one LRC nibble per frame,
// reports per-nibble parity, LRC mismatch and a saturating error count.
module nibble_parity_checker
  import nibble_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_nib,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FRAME_LEN-1:0] res_par,
  output logic                 res_lrc_err,
  output logic [CNT_W-1:0]     err_count
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           lrc;
  logic [FRAME_LEN-1:0] par_vec;
  logic                 nib_par;
  logic                 xfer;

  nibble_parity u_par (
    .nib (in_nib),
    .par (nib_par)
  );

  assign in_ready = (state != S_RESULT);
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_DATA;
      idx         <= '0;
      lrc         <= '0;
      par_vec     <= '0;
      res_valid   <= 1'b0;
      res_par     <= '0;
      res_lrc_err <= 1'b0;
      err_count   <= '0;
    end else begin
      unique case (state)
        S_DATA: begin
          if (xfer) begin
            par_vec[idx] <= nib_par;
            lrc          <= lrc ^ in_nib;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= S_CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            res_par     <= par_vec;
            res_lrc_err <= (lrc != in_nib);
            res_valid   <= 1'b1;
            if ((lrc != in_nib) && (err_count != '1))
              err_count <= err_count + 1'b1;
            state <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            lrc       <= '0;
            par_vec   <= '0;
            state     <= S_DATA;
          end
        end
        default: state <= S_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_parity_checker.sv
// Self-checking bench: two checker instances (CNT_W=8 and CNT_W=2) driven in lockstep.
module tb_nibble_parity_checker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       res_ready;
  logic [3:0] in_nib;

  logic       in_ready,  res_valid,  res_lrc_err;
  logic [7:0] res_par,   err_count;
  logic       in_ready2, res_valid2, res_lrc_err2;
  logic [7:0] res_par2;
  logic [1:0] err_count2;

  int checks   = 0;
  int failures = 0;
  int errs     = 0;
  logic [3:0] fd [8];

  always #5 clk = ~clk;

  nibble_parity_checker #(.FRAME_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_nib(in_nib), .res_valid(res_valid), .res_ready(res_ready),
    .res_par(res_par), .res_lrc_err(res_lrc_err), .err_count(err_count)
  );

  nibble_parity_checker #(.FRAME_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
    .in_nib(in_nib), .res_valid(res_valid2), .res_ready(res_ready),
    .res_par(res_par2), .res_lrc_err(res_lrc_err2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_par();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = (($countones(fd[k]) % 2) == 1);
    return r;
  endfunction

  function automatic logic [3:0] exp_lrc();
    logic [3:0] x = 4'h0;
    for (int k = 0; k < 8; k++) x = x ^ fd[k];
    return x;
  endfunction

  // Entered and left at a negedge; returns once the nibble has been accepted.
  task automatic send_nib(input logic [3:0] n, input int gap_max);
    int gaps;
    int w;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    in_valid = 1'b0;
    repeat (gaps) @(negedge clk);
    in_valid = 1'b1;
    in_nib   = n;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] chkn, input int gap_max, input int hold,
                           input logic rr_early);
    logic [7:0] ep;
    logic       el;
    int         e8, e2;
    ep = exp_par();
    el = (exp_lrc() != chkn);
    if (el) errs++;
    e8 = (errs > 255) ? 255 : errs;
    e2 = (errs > 3) ? 3 : errs;
    res_ready = rr_early;
    for (int k = 0; k < 8; k++) send_nib(fd[k], gap_max);
    send_nib(chkn, gap_max);
    chk("res_valid",   {31'd0, res_valid},    32'd1);
    chk("res_par",     {24'd0, res_par},      {24'd0, ep});
    chk("res_lrc_err", {31'd0, res_lrc_err},  {31'd0, el});
    chk("err_count",   {24'd0, err_count},    e8);
    chk("res_par2",    {24'd0, res_par2},     {24'd0, ep});
    chk("err_count2",  {30'd0, err_count2},   e2);
    chk("busy_ready",  {31'd0, in_ready},     32'd0);
    if (!rr_early) begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_nib   = 4'($urandom);
        @(negedge clk);
        chk("hold_valid", {31'd0, res_valid},   32'd1);
        chk("hold_par",   {24'd0, res_par},     {24'd0, ep});
        chk("hold_err",   {31'd0, res_lrc_err}, {31'd0, el});
        chk("hold_ready", {31'd0, in_ready},    32'd0);
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
    end
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_valid", {31'd0, res_valid}, 32'd0);
    chk("done_ready", {31'd0, in_ready},  32'd1);
    chk("kept_par",   {24'd0, res_par},   {24'd0, ep});
  endtask

  task automatic load_t2();
    fd = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h4, 4'h5, 4'h7, 4'h6};
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    errs   = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    in_nib    = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready},  32'd1);
    chk("rst_count", {24'd0, err_count}, 32'd0);
    chk("rst_par",   {24'd0, res_par},   32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Known frame, correct and wrong check nibble.
    load_t2();
    chk("t2_model_par", {24'd0, exp_par()}, 32'h5A);
    run_frame(4'h0, 0, 0, 1'b0);
    load_t2();
    run_frame(4'h1, 0, 0, 1'b0);

    // Back-pressure for 5 cycles, then a normal frame.
    load_t2();
    run_frame(4'h3, 0, 5, 1'b0);
    load_t2();
    run_frame(4'h0, 0, 0, 1'b0);

    // Random valid gaps; res_ready held high early is ignored until a result exists.
    load_t2();
    run_frame(4'h0, 3, 0, 1'b0);
    load_t2();
    run_frame(4'h0, 3, 0, 1'b1);

    // Random frames with random back-pressure.
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 8; k++) fd[k] = 4'($urandom);
      run_frame(($urandom_range(1, 0) == 1) ? exp_lrc() : 4'($urandom),
                int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)));
    end

    // Saturation of the narrow counter: 1,2,3,3,3.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 8; k++) fd[k] = 4'($urandom);
      run_frame(exp_lrc() ^ 4'h1, 1, 1, 1'b0);
    end

    // Reset in the middle of a frame discards it.
    load_t2();
    for (int k = 0; k < 3; k++) send_nib(fd[k], 0);
    resetn = 1'b0;
    errs   = 0;
    #1;
    chk("mid_rst_count",  {24'd0, err_count},  32'd0);
    chk("mid_rst_count2", {30'd0, err_count2}, 32'd0);
    chk("mid_rst_valid",  {31'd0, res_valid},  32'd0);
    chk("mid_rst_ready",  {31'd0, in_ready},   32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    load_t2();
    run_frame(4'h0, 0, 0, 1'b0);
    load_t2();
    run_frame(4'h5, 1, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
